// File: rtl/conv_encoder_punct_if.sv
// Handshake bundle between the scrambler side, the convolutional encoder and the interleaver.
// master drives data bits in and accepts coded bits; slave is the encoder.
interface conv_encoder_punct_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_bit;
    logic       in_first;
    logic       in_last;
    logic [1:0] rate;
    logic       out_valid;
    logic       out_ready;
    logic       out_bit;
    logic       out_last;

    modport master (
        output in_valid, in_bit, in_first, in_last, rate, out_ready,
        input  in_ready, out_valid, out_bit, out_last
    );

    modport slave (
        input  in_valid, in_bit, in_first, in_last, rate, out_ready,
        output in_ready, out_valid, out_bit, out_last
    );
endinterface

// File: rtl/conv_encoder_punct.sv
// 802.11a K=7 convolutional encoder (133o/171o) with rate 1/2, 2/3, 3/4 puncturing, serial output.
// Define CONV_TAIL_EN to append TAIL_LEN zero tail bits internally after each frame's last bit.
module conv_encoder_punct #(
    parameter int unsigned TAIL_LEN = 6
) (
    input logic                  clk,
    input logic                  rst,
    conv_encoder_punct_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StEmitA, StEmitB, StTail} state_e;

    state_e     state_q, state_d;
    logic [5:0] sr_q;
    logic [1:0] phase_q;
    logic [1:0] rate_q;
    logic       a_q;
    logic       b_q;
    logic       keep_b_q;
    logic       last_q;

    logic       accept;
    logic       load;
    logic       done_tail;
    logic [5:0] sr_use;
    logic [1:0] phase_use;
    logic [1:0] rate_use;
    logic       bit_use;
    logic       enc_a;
    logic       enc_b;
    logic       keep_a;
    logic       keep_b;
    logic [1:0] phase_nxt;

    assign accept = bus.in_valid & (state_q == StIdle);

`ifdef CONV_TAIL_EN
    localparam int unsigned TailW = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;

    logic [TailW-1:0] tail_cnt_q;
    logic             tail_go_q;
    logic             tail_step;
    logic             tail_final;

    assign tail_step  = (state_q == StTail);
    assign tail_final = (tail_cnt_q == TailW'(TAIL_LEN - 1));
    assign load       = accept | tail_step;
    assign done_tail  = tail_go_q;
`else
    assign load       = accept;
    assign done_tail  = 1'b0;
`endif

    // Encoder source: a fresh frame sees a cleared register, phase 0 and the newly sampled rate.
    always_comb begin
        sr_use    = sr_q;
        phase_use = phase_q;
        rate_use  = rate_q;
        bit_use   = bus.in_bit;
        if (state_q == StTail) begin
            bit_use = 1'b0;
        end else if (bus.in_first) begin
            sr_use    = 6'd0;
            phase_use = 2'd0;
            rate_use  = bus.rate;
        end
    end

    assign enc_a = bit_use ^ sr_use[1] ^ sr_use[2] ^ sr_use[4] ^ sr_use[5];
    assign enc_b = bit_use ^ sr_use[0] ^ sr_use[1] ^ sr_use[2] ^ sr_use[5];

    always_comb begin
        keep_a    = 1'b1;
        keep_b    = 1'b1;
        phase_nxt = 2'd0;
        case (rate_use)
            2'b01: begin
                keep_b    = (phase_use == 2'd0);
                phase_nxt = {1'b0, ~phase_use[0]};
            end
            2'b10: begin
                keep_a    = (phase_use != 2'd2);
                keep_b    = (phase_use != 2'd1);
                phase_nxt = (phase_use == 2'd2) ? 2'd0 : phase_use + 2'd1;
            end
            default: begin
                keep_a    = 1'b1;
                keep_b    = 1'b1;
                phase_nxt = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            sr_q       <= 6'd0;
            phase_q    <= 2'd0;
            rate_q     <= 2'b00;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            keep_b_q   <= 1'b0;
            last_q     <= 1'b0;
`ifdef CONV_TAIL_EN
            tail_cnt_q <= '0;
            tail_go_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (load) begin
                a_q      <= enc_a;
                b_q      <= enc_b;
                keep_b_q <= keep_b;
                sr_q     <= {sr_use[4:0], bit_use};
                phase_q  <= phase_nxt;
                rate_q   <= rate_use;
            end
`ifdef CONV_TAIL_EN
            if (accept) begin
                last_q     <= 1'b0;
                tail_go_q  <= bus.in_last;
                tail_cnt_q <= '0;
            end else if (tail_step) begin
                last_q     <= tail_final;
                tail_go_q  <= ~tail_final;
                tail_cnt_q <= tail_cnt_q + TailW'(1);
            end
`else
            if (accept) begin
                last_q <= bus.in_last;
            end
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = keep_a ? StEmitA : StEmitB;
                end
            end
            StEmitA: begin
                if (bus.out_ready) begin
                    if (keep_b_q) begin
                        state_d = StEmitB;
                    end else begin
                        state_d = done_tail ? StTail : StIdle;
                    end
                end
            end
            StEmitB: begin
                if (bus.out_ready) begin
                    state_d = done_tail ? StTail : StIdle;
                end
            end
            StTail: begin
`ifdef CONV_TAIL_EN
                state_d = keep_a ? StEmitA : StEmitB;
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q == StEmitA) || (state_q == StEmitB);
        bus.out_bit   = 1'b0;
        bus.out_last  = 1'b0;
        if (state_q == StEmitA) begin
            bus.out_bit  = a_q;
            bus.out_last = last_q & ~keep_b_q;
        end else if (state_q == StEmitB) begin
            bus.out_bit  = b_q;
            bus.out_last = last_q;
        end
    end

endmodule
